// File: rtl/if_trace_queue_pkg.sv
// Shared types for the gouram trace path: the trace element format and the
// serve-side state encoding used by the IF trace queue.
package gouram_datatypes;

    // One trace element as produced by the IF tracker.
    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] addr;
    } trace_output;

    // Serve FSM: idle waits for a request, release waits for it to drop.
    typedef enum logic {
        SERVE_IDLE    = 1'b0,
        SERVE_RELEASE = 1'b1
    } serve_state_t;

endpackage

// File: rtl/if_trace_queue_storage.sv
// Simple dual-port RAM holding queue entries. Writes are synchronous; the read
// port is combinational so a same-edge write to the read address is seen only
// on the following cycle (read-first behaviour).
module trace_queue_storage #(
    parameter int  DEPTH      = 16,
    parameter type entry_type = logic [95:0]
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  entry_type                wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output entry_type                rd_data
);

    entry_type mem [DEPTH];

    // Write port: at most one entry stored per cycle.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/if_trace_queue.sv
// Responder side of the request/present/valid trace handshake: buffers trace
// elements with their IF-stage end timestamps and hands them to the validity
// filter one per request, in FIFO order, while counting dropped pushes.
module if_trace_queue
    import gouram_datatypes::*;
#(
    parameter int  DEPTH            = 16,
    parameter type trace_format     = trace_output,
    parameter int  DROP_COUNT_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ready_signal,
    input  trace_format                 trace_element_in,
    input  logic [31:0]                 if_stage_end_in,
    input  logic                        data_request,
    output logic                        data_present,
    output logic                        data_valid,
    output trace_format                 trace_element_out,
    output logic [31:0]                 if_stage_end_out,
    output logic [$clog2(DEPTH):0]      occupancy,
    output logic                        overflow,
    output logic [DROP_COUNT_WIDTH-1:0] drop_count,
    input  logic                        clear_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;

    typedef struct packed {
        trace_format element;
        logic [31:0] timestamp;
    } entry_t;

    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [OW-1:0] occ_next;
    serve_state_t  state;
    serve_state_t  state_next;
    logic          pop;
    logic          full;
    logic          push_accept;
    logic          push_drop;
    entry_t        wr_entry;
    entry_t        rd_entry;

    assign full        = (occupancy == OW'(DEPTH));
    assign push_accept = ready_signal && (!full || pop);
    assign push_drop   = ready_signal && full && !pop;
    assign wr_entry    = '{element: trace_element_in, timestamp: if_stage_end_in};

    trace_queue_storage #(
        .DEPTH      (DEPTH),
        .entry_type (entry_t)
    ) u_storage (
        .clk     (clk),
        .wr_en   (push_accept),
        .wr_addr (wr_ptr),
        .wr_data (wr_entry),
        .rd_addr (rd_ptr),
        .rd_data (rd_entry)
    );

    // Serve FSM: pop once per request, then wait for the request to drop.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            SERVE_IDLE: begin
                if (data_request && (occupancy != '0)) begin
                    pop        = 1'b1;
                    state_next = SERVE_RELEASE;
                end
            end
            SERVE_RELEASE: begin
                if (!data_request) begin
                    state_next = SERVE_IDLE;
                end
            end
        endcase
    end

    // Serve FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SERVE_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Entry count after this edge; a simultaneous push and pop cancel out.
    always_comb begin
        occ_next = occupancy;
        if (push_accept && !pop) begin
            occ_next = occupancy + OW'(1);
        end else if (!push_accept && pop) begin
            occ_next = occupancy - OW'(1);
        end
    end

    // Pointers, occupancy and the registered non-empty flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            occupancy    <= '0;
            data_present <= 1'b0;
        end else begin
            if (push_accept) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            occupancy    <= occ_next;
            data_present <= (occ_next != '0);
        end
    end

    // Delivery registers: load the head entry on a pop and hold it otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_valid        <= 1'b0;
            trace_element_out <= '0;
            if_stage_end_out  <= '0;
        end else begin
            data_valid <= pop;
            if (pop) begin
                trace_element_out <= rd_entry.element;
                if_stage_end_out  <= rd_entry.timestamp;
            end
        end
    end

    // Overflow bookkeeping; a drop in the same cycle as a clear still counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (push_drop) begin
            overflow <= 1'b1;
            if (clear_overflow) begin
                drop_count <= DROP_COUNT_WIDTH'(1);
            end else if (drop_count != '1) begin
                drop_count <= drop_count + DROP_COUNT_WIDTH'(1);
            end
        end else if (clear_overflow) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end
    end

endmodule
